// File: rtl/net_chan_bridge_pkg.sv
// Shared helpers for the channel/network bridge: clog2 and the derivation
// of the channel-id and network-word widths from the channel count.
package net_chan_bridge_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A single-channel id field is never zero bits wide.
   function automatic int id_bits_of(input int chan_num);
      return (clog2(chan_num) < 1) ? 1 : clog2(chan_num);
   endfunction

   function automatic int net_bits_of(input int payload_bits, input int chan_num);
      return id_bits_of(chan_num) + payload_bits;
   endfunction

endpackage

// File: rtl/net_chan_bridge_chan_fifo.sv
// Show-ahead FIFO for one ingress channel: rd_data is the head entry whenever
// empty=0. Pushes while full and pops while empty are ignored.
module chan_fifo
   import net_chan_bridge_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/net_chan_bridge.sv
// Bridges CHAN_NUM local valid/ready channels onto one network port:
// round-robin egress into a single output register, id-routed ingress FIFOs.
module net_chan_bridge
   import net_chan_bridge_pkg::*;
#(
   parameter  int PAYLOAD_BITS = 32,
   parameter  int CHAN_NUM     = 4,
   parameter  int FIFO_DEPTH   = 4,
   localparam int ID_BITS      = id_bits_of(CHAN_NUM),
   localparam int NET_BITS     = net_bits_of(PAYLOAD_BITS, CHAN_NUM)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [PAYLOAD_BITS*CHAN_NUM-1:0] din,
   input  logic [CHAN_NUM-1:0]              val_in,
   output logic [CHAN_NUM-1:0]              ready_upward,
   output logic [PAYLOAD_BITS*CHAN_NUM-1:0] dout,
   output logic [CHAN_NUM-1:0]              val_out,
   input  logic [CHAN_NUM-1:0]              ready_downward,
   input  logic [NET_BITS-1:0]              net_din,
   input  logic                             net_val_in,
   output logic                             net_ready_upward,
   output logic [NET_BITS-1:0]              net_dout,
   output logic                             net_val_out,
   input  logic                             net_ready_downward,
   output logic [15:0]                      err_cnt
);

   // Every port moves a word only in a cycle where its valid and ready are
   // both high at the rising edge; valid never waits on ready.

   logic                    out_valid_q;
   logic [NET_BITS-1:0]     out_word_q;
   logic                    out_free;
   logic [ID_BITS-1:0]      rr_ptr;
   logic [CHAN_NUM-1:0]     hi_mask;
   logic [CHAN_NUM-1:0]     req_hi;
   logic [ID_BITS-1:0]      hi_idx;
   logic [ID_BITS-1:0]      lo_idx;
   logic [ID_BITS-1:0]      gnt_idx;
   logic                    gnt_found;
   logic [CHAN_NUM-1:0]     gnt_oh;
   logic [PAYLOAD_BITS-1:0] gnt_payload;

   assign out_free    = ~out_valid_q | net_ready_downward;
   assign net_val_out = out_valid_q & ~reset;
   assign net_dout    = out_word_q;

   // Channels strictly above the last grant win first; otherwise wrap to the lowest.
   assign hi_mask = {CHAN_NUM{1'b1}} << ({1'b0, rr_ptr} + 1'b1);
   assign req_hi  = val_in & hi_mask;

   always_comb begin
      hi_idx      = '0;
      lo_idx      = '0;
      gnt_oh      = '0;
      gnt_payload = '0;
      for (int i = CHAN_NUM - 1; i >= 0; i--) begin
         if (req_hi[i]) hi_idx = ID_BITS'(i);
         if (val_in[i]) lo_idx = ID_BITS'(i);
      end
      gnt_found = |val_in;
      gnt_idx   = (|req_hi) ? hi_idx : lo_idx;
      for (int i = 0; i < CHAN_NUM; i++) begin
         gnt_oh[i] = gnt_found && (gnt_idx == ID_BITS'(i));
         if (gnt_oh[i]) gnt_payload = din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

   assign ready_upward = (out_free && !reset) ? gnt_oh : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         rr_ptr      <= ID_BITS'(CHAN_NUM - 1);
      end else if (out_free) begin
         out_valid_q <= gnt_found;
         if (gnt_found) begin
            out_word_q <= {gnt_idx, gnt_payload};
            rr_ptr     <= gnt_idx;
         end
      end
   end

   logic [ID_BITS-1:0]  net_id;
   logic                id_ok;
   logic                sel_full;
   logic                net_accept;
   logic [CHAN_NUM-1:0] full;
   logic [CHAN_NUM-1:0] empty;
   logic [CHAN_NUM-1:0] push;
   logic [CHAN_NUM-1:0] pop;

   assign net_id = net_din[NET_BITS-1 -: ID_BITS];

   always_comb begin
      id_ok    = 1'b0;
      sel_full = 1'b0;
      for (int i = 0; i < CHAN_NUM; i++) begin
         if (net_id == ID_BITS'(i)) begin
            id_ok    = 1'b1;
            sel_full = full[i];
         end
      end
   end

   // Illegal ids are always taken so the network never stalls on them.
   assign net_ready_upward = ~reset & (~id_ok | ~sel_full);
   assign net_accept       = net_val_in & net_ready_upward;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (net_accept && !id_ok && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end

   for (genvar g = 0; g < CHAN_NUM; g++) begin : g_chan
      assign push[g]    = net_accept & (net_id == ID_BITS'(g));
      assign pop[g]     = ready_downward[g] & ~empty[g];
      assign val_out[g] = ~empty[g] & ~reset;

      chan_fifo #(
         .WIDTH (PAYLOAD_BITS),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .push    (push[g]),
         .wr_data (net_din[PAYLOAD_BITS-1:0]),
         .pop     (pop[g]),
         .rd_data (dout[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .full    (full[g]),
         .empty   (empty[g])
      );
   end

endmodule

// File: tb/tb_net_chan_bridge.sv
// Directed bench for net_chan_bridge: a 4-channel instance for arbitration,
// ingress FIFOs and reset, plus a 5-channel instance for illegal-id drops.
module tb_net_chan_bridge;

   localparam int PB  = 32;
   localparam int CN  = 4;
   localparam int IDB = 2;
   localparam int NB  = IDB + PB;
   localparam int CN5 = 5;
   localparam int NB5 = 3 + PB;

   logic               clk = 1'b0;
   logic               reset;
   logic [PB*CN-1:0]   din;
   logic [CN-1:0]      val_in;
   logic [CN-1:0]      ready_upward;
   logic [PB*CN-1:0]   dout;
   logic [CN-1:0]      val_out;
   logic [CN-1:0]      ready_downward;
   logic [NB-1:0]      net_din;
   logic               net_val_in;
   logic               net_ready_upward;
   logic [NB-1:0]      net_dout;
   logic               net_val_out;
   logic               net_ready_downward;
   logic [15:0]        err_cnt;

   logic [PB*CN5-1:0]  din5;
   logic [CN5-1:0]     val_in5;
   logic [CN5-1:0]     ready_upward5;
   logic [PB*CN5-1:0]  dout5;
   logic [CN5-1:0]     val_out5;
   logic [CN5-1:0]     ready_downward5;
   logic [NB5-1:0]     net_din5;
   logic               net_val_in5;
   logic               net_ready_upward5;
   logic [NB5-1:0]     net_dout5;
   logic               net_val_out5;
   logic               net_ready_downward5;
   logic [15:0]        err_cnt5;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [PB-1:0] exp_q[$];

   net_chan_bridge #(.PAYLOAD_BITS(PB), .CHAN_NUM(CN), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .din(din), .val_in(val_in), .ready_upward(ready_upward),
      .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
      .net_din(net_din), .net_val_in(net_val_in), .net_ready_upward(net_ready_upward),
      .net_dout(net_dout), .net_val_out(net_val_out),
      .net_ready_downward(net_ready_downward), .err_cnt(err_cnt)
   );

   net_chan_bridge #(.PAYLOAD_BITS(PB), .CHAN_NUM(CN5), .FIFO_DEPTH(4)) dut5 (
      .clk(clk), .reset(reset), .din(din5), .val_in(val_in5), .ready_upward(ready_upward5),
      .dout(dout5), .val_out(val_out5), .ready_downward(ready_downward5),
      .net_din(net_din5), .net_val_in(net_val_in5), .net_ready_upward(net_ready_upward5),
      .net_dout(net_dout5), .net_val_out(net_val_out5),
      .net_ready_downward(net_ready_downward5), .err_cnt(err_cnt5)
   );

   // clock
   always #5 clk = ~clk;

   typedef struct {
      logic [CN-1:0]  val;
      logic           nrd;
      logic [CN-1:0]  exp_rdy;
      logic           exp_nv;
      logic [IDB-1:0] exp_id;
   } rr_vec_t;

   rr_vec_t rr_tab[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PB-1:0] base_payload(input int ch);
      return 32'hC0DE_0000 | PB'(ch);
   endfunction

   // driver: offer one ingress word for a single cycle and check the ready it sees
   task automatic push_word(input logic [IDB-1:0] id, input logic [PB-1:0] pl,
                            input logic exp_rdy, input string name);
      net_din    = {id, pl};
      net_val_in = 1'b1;
      #1;
      check(name, 64'(net_ready_upward), 64'(exp_rdy));
      step();
      net_val_in = 1'b0;
   endtask

   // scoreboard: pop n words from channel ch, comparing against exp_q in order
   task automatic drain_check(input int ch, input int n, input string name);
      logic [PB-1:0] exp_w;
      ready_downward[ch] = 1'b1;
      for (int k = 0; k < n; k++) begin
         exp_w = exp_q.pop_front();
         check({name, "_valid"}, 64'(val_out[ch]), 64'd1);
         check({name, "_data"}, 64'(dout[ch*PB +: PB]), 64'(exp_w));
         step();
      end
      ready_downward[ch] = 1'b0;
      #1;
      check({name, "_empty"}, 64'(val_out[ch]), 64'd0);
   endtask

   initial begin
      // round-robin vectors: {val_in, net_ready_downward, ready_upward, net_val_out next, id next}
      rr_tab[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      rr_tab[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      rr_tab[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      rr_tab[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      rr_tab[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      rr_tab[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
      rr_tab[6] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
      rr_tab[7] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      rr_tab[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
      rr_tab[9] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

      // reset, with traffic offered on every input
      reset = 1'b1;
      for (int i = 0; i < CN; i++) din[i*PB +: PB] = base_payload(i);
      din5 = '0; val_in5 = '0; ready_downward5 = '0; net_din5 = '0;
      net_val_in5 = 1'b0; net_ready_downward5 = 1'b0;
      val_in = 4'b1111; ready_downward = '0; net_din = '0; net_val_in = 1'b1;
      net_ready_downward = 1'b1;
      step();
      step();
      check("rst_ready_upward", 64'(ready_upward), 64'd0);
      check("rst_net_ready_upward", 64'(net_ready_upward), 64'd0);
      check("rst_net_val_out", 64'(net_val_out), 64'd0);
      check("rst_val_out", 64'(val_out), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_err_cnt5", 64'(err_cnt5), 64'd0);
      val_in = '0; net_val_in = 1'b0;
      reset = 1'b0;
      step();

      // round-robin egress table
      for (int r = 0; r < 10; r++) begin
         val_in             = rr_tab[r].val;
         net_ready_downward = rr_tab[r].nrd;
         #1;
         check($sformatf("rr%0d_ready_upward", r), 64'(ready_upward), 64'(rr_tab[r].exp_rdy));
         step();
         check($sformatf("rr%0d_net_val_out", r), 64'(net_val_out), 64'(rr_tab[r].exp_nv));
         if (rr_tab[r].exp_nv)
            check($sformatf("rr%0d_net_dout", r), 64'(net_dout),
                  64'({rr_tab[r].exp_id, base_payload(int'(rr_tab[r].exp_id))}));
      end

      // stalled output register holds its word and blocks all channels
      din[2*PB +: PB]    = 32'hA5A5_0002;
      val_in             = 4'b0100;
      net_ready_downward = 1'b0;
      #1;
      check("stall_first_grant", 64'(ready_upward), 64'b0100);
      step();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d_ready_upward", c), 64'(ready_upward), 64'd0);
         check($sformatf("stall%0d_net_val_out", c), 64'(net_val_out), 64'd1);
         check($sformatf("stall%0d_net_dout", c), 64'(net_dout), 64'({2'd2, 32'hA5A5_0002}));
         step();
      end
      val_in             = 4'b1111;
      net_ready_downward = 1'b1;
      #1;
      check("stall_ptr_next", 64'(ready_upward), 64'b1000);
      step();
      check("stall_after_dout", 64'(net_dout), 64'({2'd3, base_payload(3)}));
      val_in = '0;
      din[2*PB +: PB] = base_payload(2);
      step();
      check("egress_idle", 64'(net_val_out), 64'd0);

      // five words to channel 1 with a four-deep FIFO
      for (int k = 0; k < 5; k++) exp_q.push_back(32'h1111_0000 + PB'(k));
      push_word(2'd1, exp_q[0], 1'b1, "ch1_push0");
      check("ch1_latency_valid", 64'(val_out[1]), 64'd1);
      check("ch1_latency_data", 64'(dout[1*PB +: PB]), 64'(exp_q[0]));
      for (int k = 1; k < 4; k++) push_word(2'd1, exp_q[k], 1'b1, $sformatf("ch1_push%0d", k));
      net_din    = {2'd1, exp_q[4]};
      net_val_in = 1'b1;
      #1;
      check("ch1_full_ready", 64'(net_ready_upward), 64'd0);
      step();
      check("ch1_full_ready_hold", 64'(net_ready_upward), 64'd0);
      ready_downward[1] = 1'b1;
      #1;
      check("ch1_pop_no_bypass", 64'(net_ready_upward), 64'd0);
      check("ch1_pop_data", 64'(dout[1*PB +: PB]), 64'(exp_q.pop_front()));
      step();
      ready_downward[1] = 1'b0;
      #1;
      check("ch1_fifth_ready", 64'(net_ready_upward), 64'd1);
      step();
      net_val_in = 1'b0;
      drain_check(1, 4, "ch1_drain");

      // full FIFO[3] popped in the same cycle a word for it arrives
      for (int k = 0; k < 5; k++) exp_q.push_back(32'h3333_0000 + PB'(k));
      for (int k = 0; k < 4; k++) push_word(2'd3, exp_q[k], 1'b1, $sformatf("ch3_push%0d", k));
      net_din           = {2'd3, exp_q[4]};
      net_val_in        = 1'b1;
      ready_downward[3] = 1'b1;
      #1;
      check("ch3_pop_push_ready", 64'(net_ready_upward), 64'd0);
      check("ch3_pop_data", 64'(dout[3*PB +: PB]), 64'(exp_q.pop_front()));
      step();
      ready_downward[3] = 1'b0;
      #1;
      check("ch3_next_ready", 64'(net_ready_upward), 64'd1);
      step();
      net_val_in = 1'b0;
      drain_check(3, 4, "ch3_drain");
      check("legal_ids_no_err", 64'(err_cnt), 64'd0);

      // reset with three words queued on channel 0 and a word in the output register
      for (int k = 0; k < 3; k++) push_word(2'd0, 32'h0000_BEE0 + PB'(k), 1'b1, $sformatf("ch0_push%0d", k));
      val_in             = 4'b0001;
      net_ready_downward = 1'b0;
      step();
      check("pre_rst_net_val_out", 64'(net_val_out), 64'd1);
      check("pre_rst_val_out0", 64'(val_out[0]), 64'd1);
      reset      = 1'b1;
      val_in     = 4'b1111;
      net_din    = {2'd0, 32'h0};
      net_val_in = 1'b1;
      step();
      check("mid_rst_val_out", 64'(val_out), 64'd0);
      check("mid_rst_net_val_out", 64'(net_val_out), 64'd0);
      check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("mid_rst_ready_upward", 64'(ready_upward), 64'd0);
      check("mid_rst_net_ready", 64'(net_ready_upward), 64'd0);
      reset              = 1'b0;
      val_in             = '0;
      net_val_in         = 1'b0;
      net_ready_downward = 1'b1;
      step();
      step();
      check("post_rst_net_val_out", 64'(net_val_out), 64'd0);
      check("post_rst_val_out", 64'(val_out), 64'd0);

      // five-channel instance: ids 5, 6, 7 are dropped and counted
      for (int id = 5; id < 8; id++) begin
         net_din5    = {3'(id), 32'hDEAD_0000 | PB'(id)};
         net_val_in5 = 1'b1;
         #1;
         check($sformatf("drop_id%0d_ready", id), 64'(net_ready_upward5), 64'd1);
         step();
      end
      net_val_in5 = 1'b0;
      #1;
      check("drop_err_cnt3", 64'(err_cnt5), 64'd3);
      check("drop_no_val_out", 64'(val_out5), 64'd0);
      net_din5    = {3'd7, 32'h0};
      net_val_in5 = 1'b1;
      repeat (69997) @(posedge clk);
      #1;
      net_val_in5 = 1'b0;
      step();
      check("drop_err_cnt_sat", 64'(err_cnt5), 64'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/net_chan_bridge.md
NET_CHAN_BRIDGE -- requirements
Module: net_chan_bridge

Interface
REQ-001 The module SHALL take parameter PAYLOAD_BITS, default 32, meaning the per-channel payload width in bits.
REQ-002 The module SHALL take parameter CHAN_NUM, default 4, meaning the number of local channels, legal range 2..16.
REQ-003 The module SHALL take parameter FIFO_DEPTH, default 4, meaning the ingress FIFO depth per channel, a power of two and at least 2.
REQ-004 The module SHALL derive ID_BITS = max(1, clog2(CHAN_NUM)) and NET_BITS = ID_BITS+PAYLOAD_BITS as local parameters; both SHALL be non-overridable.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 din  in  PAYLOAD_BITS*CHAN_NUM  egress payloads; channel i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 val_in  in  CHAN_NUM  per-channel egress valid.
REQ-009 ready_upward  out  CHAN_NUM  per-channel egress ready.
REQ-010 dout  out  PAYLOAD_BITS*CHAN_NUM  ingress payloads; packed the same way as din.
REQ-011 val_out  out  CHAN_NUM  per-channel ingress valid.
REQ-012 ready_downward  in  CHAN_NUM  per-channel ingress ready.
REQ-013 net_din  in  NET_BITS  network word; {id[ID_BITS-1:0], payload}.
REQ-014 net_val_in / net_ready_upward  in / out  1 / 1  network ingress handshake.
REQ-015 net_dout  out  NET_BITS  network egress word; {source channel id, payload}.
REQ-016 net_val_out / net_ready_downward  out / in  1 / 1  network egress handshake.
REQ-017 err_cnt  out  16  count of dropped ingress words with an illegal id.

Function
REQ-018 A transfer SHALL occur on any port only in a cycle where valid and ready are both high at the rising edge.
REQ-019 Egress: a single output register SHALL hold net_dout/net_val_out; the register is free when net_val_out=0 or net_ready_downward=1.
REQ-020 Egress: when the output register is free, a round-robin arbiter SHALL grant the first requesting channel after the last granted index, wrapping from CHAN_NUM-1 to 0; ready_upward SHALL be one-hot on the grant, or all zero.
REQ-021 The round-robin pointer SHALL advance only on an accepted egress transfer; it SHALL NOT move while the output register is stalled.
REQ-022 The accepted word SHALL appear on net_dout with net_val_out=1 on the next cycle (latency 1); throughput SHALL be 1 word/cycle under continuous net_ready_downward.
REQ-023 net_dout and net_val_out SHALL hold stable while net_val_out=1 and net_ready_downward=0.
REQ-024 Ingress: each channel SHALL have a show-ahead FIFO of FIFO_DEPTH entries driving dout/val_out for that channel.
REQ-025 For id<CHAN_NUM, net_ready_upward SHALL equal NOT full of FIFO[id] in the current cycle; there is no full-FIFO bypass, so a simultaneous pop does not raise ready.
REQ-026 An accepted word SHALL be visible on val_out[id] on the next cycle (latency 1).
REQ-027 For id>=CHAN_NUM, net_ready_upward SHALL be 1, the word SHALL be discarded, and err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-028 On each FIFO, a simultaneous push and pop SHALL keep occupancy unchanged; a push on a full FIFO and a pop on an empty FIFO SHALL be impossible by construction.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order within each channel SHALL be preserved.

Reset
REQ-030 While reset=1: net_val_out=0, val_out=0, ready_upward=0, err_cnt=0, all FIFOs empty, round-robin pointer so that channel 0 has top priority; net_ready_upward SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL discard the output register and all FIFO contents; no word SHALL be emitted after reset deasserts unless it is newly accepted.

Structure
REQ-032 A shared package SHALL hold the clog2 function and the ID_BITS/NET_BITS derivation helpers.
REQ-033 The per-channel FIFO SHALL be the sub-module chan_fifo (parameters WIDTH and DEPTH; push/pop/full/empty), instantiated CHAN_NUM times via generate.

Verification (CHAN_NUM=4, PAYLOAD_BITS=32, FIFO_DEPTH=4)
REQ-034 Channels 0..3 all valid, net_ready_downward=1 -> net_dout ids 0,1,2,3,0,... one per cycle; net_val_out first high 1 cycle after the first accept.
REQ-035 Channel 2 valid with 32'hA5A5_0002, net_ready_downward=0 for 5 cycles -> net_dout={2'd2,32'hA5A5_0002} held stable, ready_upward=0, pointer unchanged.
REQ-036 Five words to id 1 with ready_downward[1]=0 -> four accepted, net_ready_upward=0 on the fifth; after one pop the fifth is accepted the following cycle; order preserved.
REQ-037 FIFO[3] full and popped in the same cycle a word for id 3 arrives -> net_ready_upward=0 that cycle; the word is accepted next cycle.
REQ-038 Reset asserted with 3 words in FIFO[0] and net_val_out=1 -> next cycle val_out=0, net_val_out=0, err_cnt=0.
REQ-039 Widened to CHAN_NUM=5 (ID_BITS=3): words with id 5, 6, 7 -> all accepted and dropped, err_cnt=3; 70000 such words -> err_cnt=16'hFFFF.
